// File: rtl/stack_ctrl.sv
// Sequencer for an external 6-entry hardware stack: accepts one command at a
// time, issues load/push/pop strobes and tracks depth plus a sticky error code.
module stack_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd,
  input  logic [15:0] din,
  input  logic [15:0] qtop,
  input  logic [15:0] qnext,
  output logic        load,
  output logic        push,
  output logic        pop,
  output logic [15:0] d,
  output logic [2:0]  depth,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE and never in reset.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MUL, S_WB} state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  localparam logic [2:0] MAX_DEPTH = 3'd6;

  state_t      r_state;
  logic [2:0]  r_cmd;
  logic [15:0] r_din;
  logic [15:0] r_qtop;
  logic [15:0] r_qnext;
  logic [15:0] r_acc;
  logic [3:0]  r_cnt;
  logic [2:0]  r_depth;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic        r_load;
  logic        r_push;
  logic        r_pop;
  logic [15:0] r_d;
  logic        r_done;

  logic w_accept;
  logic w_ovf;
  logic w_unf;
  logic w_two_op;

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_two_op = (r_cmd == OP_ADD) || (r_cmd == OP_SUB) || (r_cmd == OP_MUL);
  assign w_ovf    = ((r_cmd == OP_PUSH) || (r_cmd == OP_DUP)) && (r_depth == MAX_DEPTH);
  assign w_unf    = (((r_cmd == OP_DROP) || (r_cmd == OP_DUP)) && (r_depth == 3'd0)) ||
                    (w_two_op && (r_depth < 3'd2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= OP_NOP;
      r_din      <= '0;
      r_qtop     <= '0;
      r_qnext    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_load     <= 1'b0;
      r_push     <= 1'b0;
      r_pop      <= 1'b0;
      r_d        <= '0;
      r_done     <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_push <= 1'b0;
      r_pop  <= 1'b0;
      r_d    <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd   <= cmd;
            r_din   <= din;
            r_qtop  <= qtop;
            r_qnext <= qnext;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ((cmd == OP_MUL) && (r_depth >= 3'd2)) ? S_MUL : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          if (w_ovf) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd1;
          end else if (w_unf) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd2;
          end else begin
            case (r_cmd)
              OP_PUSH: begin
                r_load  <= 1'b1;
                r_push  <= 1'b1;
                r_d     <= r_din;
                r_depth <= r_depth + 3'd1;
              end
              OP_DROP: begin
                r_pop   <= 1'b1;
                r_depth <= r_depth - 3'd1;
              end
              OP_DUP: begin
                r_push  <= 1'b1;
                r_depth <= r_depth + 3'd1;
              end
              OP_ADD: begin
                r_load  <= 1'b1;
                r_pop   <= 1'b1;
                r_d     <= r_qnext + r_qtop;
                r_depth <= r_depth - 3'd1;
              end
              OP_SUB: begin
                r_load  <= 1'b1;
                r_pop   <= 1'b1;
                r_d     <= r_qnext - r_qtop;
                r_depth <= r_depth - 3'd1;
              end
              OP_CLR: begin
                r_depth    <= '0;
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          // Operand latches double as the shift registers: qnext is the
          // left-shifting multiplicand, qtop the right-shifting multiplier.
          r_acc   <= r_acc + (r_qtop[0] ? r_qnext : 16'd0);
          r_qnext <= {r_qnext[14:0], 1'b0};
          r_qtop  <= {1'b0, r_qtop[15:1]};
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_WB;
        end
        S_WB: begin
          r_load  <= 1'b1;
          r_pop   <= 1'b1;
          r_d     <= r_acc;
          r_depth <= r_depth - 3'd1;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load     = r_load;
  assign push     = r_push;
  assign pop      = r_pop;
  assign d        = r_d;
  assign done     = r_done;
  assign depth    = r_depth;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed vector table, reset corner cases and random
// commands checked against a queue-based stack model.
module tb_stack_ctrl;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3;
  localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, MUL = 3'd6, CLR = 3'd7;

  typedef struct {
    logic [2:0]  c;
    logic [15:0] din;
    logic        ld;
    logic        ps;
    logic        pp;
    logic [15:0] d;
    logic [2:0]  dep;
    logic        er;
    logic [1:0]  code;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd = 3'd0;
  logic [15:0] din = 16'd0;
  logic [15:0] qtop;
  logic [15:0] qnext;
  logic        load, push, pop, done, err;
  logic [15:0] d;
  logic [2:0]  depth;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  // Environment stack: six words, shifted by the DUT strobes
  logic [15:0] stk [6];

  // Reference model state
  logic [15:0] mq[$];
  logic        m_err = 1'b0;
  logic [1:0]  m_code = 2'd0;

  vec_t tbl[$];

  stack_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .din(din), .qtop(qtop), .qnext(qnext),
    .load(load), .push(push), .pop(pop), .d(d), .depth(depth),
    .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 6; i++) stk[i] = 16'd0;

  always @(posedge clk) begin
    if (push) for (int i = 5; i > 0; i--) stk[i] <= stk[i-1];
    if (pop)  for (int i = 0; i < 5; i++) stk[i] <= stk[i+1];
    if (load) stk[0] <= d;
  end

  assign qtop  = stk[0];
  assign qnext = stk[1];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] c, input logic [15:0] v,
                              input logic ld, input logic ps, input logic pp,
                              input logic [15:0] dd, input logic [2:0] dep,
                              input logic er, input logic [1:0] code, input int lat);
    vec_t e;
    e.c = c; e.din = v; e.ld = ld; e.ps = ps; e.pp = pp; e.d = dd;
    e.dep = dep; e.er = er; e.code = code; e.lat = lat;
    return e;
  endfunction

  // Stack semantics from the opcode rules; index 0 of the queue is the top.
  task automatic model(input logic [2:0] c, input logic [15:0] v, output vec_t e);
    logic [15:0] a, b, r;
    logic [31:0] p;
    e = mk(c, v, 0, 0, 0, 16'd0, 3'd0, 0, 2'd0, 2);
    case (c)
      PUSH: if (mq.size() == 6) begin m_err = 1; m_code = 2'd1; end
            else begin e.ld = 1; e.ps = 1; e.d = v; mq.push_front(v); end
      DROP: if (mq.size() == 0) begin m_err = 1; m_code = 2'd2; end
            else begin e.pp = 1; void'(mq.pop_front()); end
      DUP:  if (mq.size() == 0) begin m_err = 1; m_code = 2'd2; end
            else if (mq.size() == 6) begin m_err = 1; m_code = 2'd1; end
            else begin e.ps = 1; mq.push_front(mq[0]); end
      ADD, SUB, MUL:
            if (mq.size() < 2) begin m_err = 1; m_code = 2'd2; end
            else begin
              a = mq[0]; b = mq[1];
              p = 32'(b) * 32'(a);
              r = (c == ADD) ? b + a : (c == SUB) ? b - a : p[15:0];
              void'(mq.pop_front()); void'(mq.pop_front()); mq.push_front(r);
              e.ld = 1; e.pp = 1; e.d = r;
              if (c == MUL) e.lat = 18;
            end
      CLR:  begin mq.delete(); m_err = 0; m_code = 2'd0; end
      default: ;
    endcase
    e.dep = 3'(mq.size()); e.er = m_err; e.code = m_code;
  endtask

  // Issue one command starting at a negedge; returns what the DUT did.
  task automatic run_cmd(input logic [2:0] c, input logic [15:0] v, output vec_t o);
    int n;
    bit stray;
    o = mk(c, v, 0, 0, 0, 16'd0, 3'd0, 0, 2'd0, -1);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmp("ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd = c; din = v;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    stray = 0;
    while (!done && n < 40) begin
      if (load || push || pop || cmd_ready) stray = 1;
      @(negedge clk);
      n++;
    end
    cmp("busy_quiet", {31'd0, stray}, 32'd0);
    o.ld = load; o.ps = push; o.pp = pop; o.d = d;
    o.dep = depth; o.er = err; o.code = err_code;
    o.lat = done ? n : -1;
    @(negedge clk);
    cmp("pulse_once", {28'd0, done, load, push, pop}, 32'd0);
  endtask

  task automatic check_vec(input string tag, input vec_t o, input vec_t e);
    cmp({tag, "_load"},  {31'd0, o.ld}, {31'd0, e.ld});
    cmp({tag, "_push"},  {31'd0, o.ps}, {31'd0, e.ps});
    cmp({tag, "_pop"},   {31'd0, o.pp}, {31'd0, e.pp});
    cmp({tag, "_d"},     {16'd0, o.d},  {16'd0, e.d});
    cmp({tag, "_depth"}, {29'd0, o.dep}, {29'd0, e.dep});
    cmp({tag, "_err"},   {31'd0, o.er}, {31'd0, e.er});
    cmp({tag, "_code"},  {30'd0, o.code}, {30'd0, e.code});
    cmp({tag, "_lat"},   o.lat, e.lat);
  endtask

  initial begin
    vec_t o, e;
    logic [2:0] rc;
    int r;

    // Directed table: {cmd, din, load, push, pop, d, depth, err, code, latency}
    tbl.push_back(mk(ADD,  0, 0, 0, 0, 16'd0,      0, 1, 2, 2));
    tbl.push_back(mk(CLR,  0, 0, 0, 0, 16'd0,      0, 0, 0, 2));
    tbl.push_back(mk(DROP, 0, 0, 0, 0, 16'd0,      0, 1, 2, 2));
    tbl.push_back(mk(CLR,  0, 0, 0, 0, 16'd0,      0, 0, 0, 2));
    tbl.push_back(mk(PUSH, 3, 1, 1, 0, 16'd3,      1, 0, 0, 2));
    tbl.push_back(mk(PUSH, 5, 1, 1, 0, 16'd5,      2, 0, 0, 2));
    tbl.push_back(mk(ADD,  0, 1, 0, 1, 16'd8,      1, 0, 0, 2));
    tbl.push_back(mk(DROP, 0, 0, 0, 1, 16'd0,      0, 0, 0, 2));
    tbl.push_back(mk(PUSH, 10, 1, 1, 0, 16'd10,    1, 0, 0, 2));
    tbl.push_back(mk(PUSH, 3, 1, 1, 0, 16'd3,      2, 0, 0, 2));
    tbl.push_back(mk(SUB,  0, 1, 0, 1, 16'd7,      1, 0, 0, 2));
    tbl.push_back(mk(PUSH, 1, 1, 1, 0, 16'd1,      2, 0, 0, 2));
    tbl.push_back(mk(PUSH, 2, 1, 1, 0, 16'd2,      3, 0, 0, 2));
    tbl.push_back(mk(SUB,  0, 1, 0, 1, 16'hFFFF,   2, 0, 0, 2));
    tbl.push_back(mk(DUP,  0, 0, 1, 0, 16'd0,      3, 0, 0, 2));
    tbl.push_back(mk(NOP,  0, 0, 0, 0, 16'd0,      3, 0, 0, 2));
    tbl.push_back(mk(CLR,  0, 0, 0, 0, 16'd0,      0, 0, 0, 2));
    tbl.push_back(mk(PUSH, 300, 1, 1, 0, 16'd300,  1, 0, 0, 2));
    tbl.push_back(mk(PUSH, 300, 1, 1, 0, 16'd300,  2, 0, 0, 2));
    tbl.push_back(mk(MUL,  0, 1, 0, 1, 16'h5F90,   1, 0, 0, 18));
    tbl.push_back(mk(MUL,  0, 0, 0, 0, 16'd0,      1, 1, 2, 2));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(PUSH, 16'(11 + i), 1, 1, 0, 16'(11 + i), 3'(2 + i), 1, 2, 2));
    tbl.push_back(mk(PUSH, 99, 0, 0, 0, 16'd0,     6, 1, 1, 2));
    tbl.push_back(mk(CLR,  0, 0, 0, 0, 16'd0,      0, 0, 0, 2));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(PUSH, 16'(i + 1), 1, 1, 0, 16'(i + 1), 3'(i + 1), 0, 0, 2));
    tbl.push_back(mk(PUSH, 7, 0, 0, 0, 16'd0,      6, 1, 1, 2));
    tbl.push_back(mk(DUP,  0, 0, 0, 0, 16'd0,      6, 1, 1, 2));
    tbl.push_back(mk(DROP, 0, 0, 0, 1, 16'd0,      5, 1, 1, 2));
    tbl.push_back(mk(CLR,  0, 0, 0, 0, 16'd0,      0, 0, 0, 2));

    // Reset values
    repeat (3) @(negedge clk);
    cmp("rst_ready", {31'd0, cmd_ready}, 32'd0);
    cmp("rst_strobes", {27'd0, load, push, pop, done, err}, 32'd0);
    cmp("rst_d", {16'd0, d}, 32'd0);
    cmp("rst_depth", {27'd0, depth, err_code}, 32'd0);
    rst = 1'b0;
    #1;
    cmp("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    foreach (tbl[i]) begin
      model(tbl[i].c, tbl[i].din, e);
      run_cmd(tbl[i].c, tbl[i].din, o);
      check_vec($sformatf("vec%0d", i), o, tbl[i]);
    end

    // Reset in the eighth cycle of a MUL discards it
    model(PUSH, 16'd2, e); run_cmd(PUSH, 16'd2, o); check_vec("mr_push0", o, e);
    model(PUSH, 16'd3, e); run_cmd(PUSH, 16'd3, o); check_vec("mr_push1", o, e);
    cmd_valid = 1'b1; cmd = MUL; din = 16'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    cmp("mr_busy", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cmp("mr_no_strobe", {28'd0, load, push, pop, done}, 32'd0);
    cmp("mr_d", {16'd0, d}, 32'd0);
    cmp("mr_state", {26'd0, depth, err, err_code}, 32'd0);
    cmp("mr_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    mq.delete(); m_err = 0; m_code = 2'd0;
    #1;
    cmp("mr_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmp("mr_no_done", {30'd0, done, load}, 32'd0);

    // Random commands against the model
    for (int k = 0; k < 250; k++) begin
      r  = $urandom_range(0, 10);
      rc = (r >= 8) ? PUSH : 3'(r);
      din = 16'($urandom_range(0, 65535));
      model(rc, din, e);
      run_cmd(rc, din, o);
      check_vec($sformatf("rnd%0d", k), o, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The block SHALL have the following ports:
- clk        input   1   rising-edge clock
- rst        input   1   synchronous reset, active-high
- cmd_valid  input   1   command offered
- cmd_ready  output  1   command accepted when cmd_valid and cmd_ready are both high
- cmd        input   3   opcode: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 ADD, 5 SUB, 6 MUL, 7 CLR
- din        input   16  PUSH operand
- qtop       input   16  stack top word
- qnext      input   16  stack second word
- load       output  1   stack strobe: write d into the top entry
- push       output  1   stack strobe: shift entries down
- pop        output  1   stack strobe: shift entries up
- d          output  16  data to the stack top
- depth      output  3   valid entry count, 0..6
- done       output  1   one-cycle pulse when a command completes
- err        output  1   sticky error flag
- err_code   output  2   0 none, 1 overflow, 2 underflow

Function
REQ-002 The FSM SHALL have four states: IDLE, ISSUE, MUL, WB. cmd_ready SHALL equal (state==IDLE) and SHALL be 0 while rst is high.
REQ-003 On acceptance the block SHALL latch cmd, din, qtop and qnext, then go to ISSUE. For MUL with no error it SHALL go to MUL instead.
REQ-004 load, push, pop, d and done SHALL be registered outputs. They SHALL be asserted only in the cycle after ISSUE or WB is entered, for exactly one cycle.
REQ-005 Strobes in the ISSUE cycle SHALL be, by command:
- PUSH: load=1, push=1, d=din; depth+1.
- DROP: pop=1; depth-1.
- DUP: push=1; depth+1.
- ADD: load=1, pop=1, d=qnext+qtop; depth-1.
- SUB: load=1, pop=1, d=qnext-qtop; depth-1.
- NOP and CLR: no strobes.
REQ-006 All arithmetic SHALL be modulo 2^16, with no carry or overflow flag.
REQ-007 MUL SHALL run a 16-iteration shift-add over the latched operands, one iteration per cycle. It SHALL then enter WB and issue load=1, pop=1, d=low 16 bits of qnext*qtop; depth-1.
REQ-008 Every command SHALL complete with exactly one done pulse and then return to IDLE. Accept-to-done latency SHALL be 2 cycles for non-MUL commands and 18 cycles for MUL.
REQ-009 Overflow is PUSH or DUP at depth==6. It SHALL produce no strobes and leave depth unchanged. It SHALL set err=1 and err_code=1, with done still pulsed.
REQ-010 Underflow is any of the following; it SHALL produce no strobes and leave depth unchanged, and it SHALL set err=1 and err_code=2, with done still pulsed:
- DROP or DUP at depth==0;
- ADD, SUB or MUL at depth<2 (MUL skips the MUL state).
REQ-011 err and err_code SHALL hold until CLR or rst. A later error SHALL overwrite err_code with the newest code.
REQ-012 CLR SHALL set depth=0, err=0 and err_code=0. Stack contents SHALL NOT be cleared (the stack has no reset).
REQ-013 cmd_valid SHALL be ignored in every state except IDLE. No command SHALL be queued.
REQ-014 push and pop SHALL never be asserted together.

Reset
REQ-015 With rst high at a clock edge, the block SHALL set state=IDLE, depth=0, err=0, err_code=0, load=push=pop=done=0 and d=0.
REQ-016 rst SHALL override any state, including mid-MUL. The in-flight command SHALL be discarded, with no strobe and no done.
REQ-017 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- PUSH 3, PUSH 5, ADD -> ADD issues load=1, pop=1, d=8; depth 2->1; done 2 cycles after acceptance.
- PUSH 10, PUSH 3, SUB -> d=7; PUSH 1, PUSH 2, SUB -> d=16'hFFFF.
- PUSH 300, PUSH 300, MUL -> done 18 cycles after acceptance; d=16'h5F90 (90000 mod 65536); depth 1; cmd_ready 0 throughout.
- Seven PUSHes -> first six increment depth to 6; seventh gives no strobe, err=1, err_code=1, depth 6. CLR -> depth 0, err 0.
- From reset, ADD -> err_code=2, no strobes. DROP at depth 0 -> err_code=2.
- rst asserted at cycle 8 of a MUL -> no load, no done; next cycle idle values, cmd_ready=1 after rst drops.
